t_ff_updown_counter: RTL and testbench

Parameterised synchronous modulo-N up/down counter whose state lives entirely in T flip-flop cells. The block drives each cell's toggle input from next-state logic and reads back the cell outputs. It is the toggle-generation stage that sits directly upstream of the T flip-flop. It replaces hand-wired 3-bit T-FF counters in the sequential examples with one reusable, load/enable/direction-capable counter.

---
 rtl/t_ff_updown_counter_pkg.sv | 13 +
 rtl/t_ff_updown_counter_cell.sv | 15 +
 rtl/t_ff_updown_counter.sv | 103 ++++++++++
 tb/tb_t_ff_updown_counter.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/t_ff_updown_counter_pkg.sv
// Shared constants for the T-FF counter examples, plus the
// elaboration-time legality check for the counter parameters.
package t_ff_updown_counter_pkg;

   localparam int MAX_WIDTH = 16;

   // True when WIDTH is supported and 2 <= MODULUS <= 2^WIDTH.
   function automatic bit modulus_ok(input int width, input int modulus);
      return (width >= 1) && (width <= MAX_WIDTH) &&
             (modulus >= 2) && (modulus <= (1 << width));
   endfunction

endpackage

// File: rtl/t_ff_updown_counter_cell.sv
// Single T flip-flop storage cell: toggles on t, synchronous clear.
module t_ff_cell (
   input  logic clk,
   input  logic clr,
   input  logic t,
   output logic q
);

   // Clear has priority over toggle; no direct data path into the cell.
   always_ff @(posedge clk) begin
      if (clr)    q <= 1'b0;
      else if (t) q <= ~q;
   end

endmodule

// File: rtl/t_ff_updown_counter.sv
// Modulo-MODULUS up/down counter whose state lives in T-FF cells.
// This block only computes the next count, turns it into toggles,
// decodes terminal count and registers the wrap / load-error pulses.
module t_ff_updown_counter #(
   parameter int WIDTH   = 3,
   parameter int MODULUS = 8
) (
   input  logic             clk,
   input  logic             clr,
   input  logic             en,
   input  logic             up,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap,
   output logic             load_err
);
   import t_ff_updown_counter_pkg::*;

   if (!modulus_ok(WIDTH, MODULUS)) begin : g_bad_modulus
      $error("t_ff_updown_counter: illegal WIDTH/MODULUS combination");
   end

   // Comparisons are done one bit wider so MODULUS = 2^WIDTH is representable.
   localparam logic [WIDTH-1:0] LAST    = WIDTH'(MODULUS - 1);
   localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MODULUS);

   logic [WIDTH-1:0] w_next;
   logic [WIDTH-1:0] w_t;
   logic             w_wrap;
   logic             w_load_err;
   logic             w_d_ok;
   logic             w_at_last;
   logic             w_at_zero;
   logic             w_q_over;
   logic             r_wrap;
   logic             r_load_err;

   assign w_d_ok    = ({1'b0, d} < MOD_EXT);
   assign w_at_last = (q == LAST);
   assign w_at_zero = (q == '0);
   assign w_q_over  = ({1'b0, q} >= MOD_EXT);

   // Next-state selection: load beats enable, enable beats hold.
   always_comb begin
      w_next     = q;
      w_wrap     = 1'b0;
      w_load_err = 1'b0;
      if (load) begin
         if (w_d_ok) w_next     = d;
         else        w_load_err = 1'b1;
      end else if (en) begin
         if (up) begin
            if (w_at_last) begin
               w_next = '0;
               w_wrap = 1'b1;
            end else if (w_q_over) begin
               w_next = '0;
            end else begin
               w_next = q + WIDTH'(1);
            end
         end else begin
            if (w_at_zero) begin
               w_next = LAST;
               w_wrap = 1'b1;
            end else begin
               w_next = q - WIDTH'(1);
            end
         end
      end
   end

   // A bit toggles exactly where current and next count differ.
   assign w_t = q ^ w_next;

   // Terminal count: this edge will wrap.
   assign tc = en & ~load & (up ? w_at_last : w_at_zero);

   for (genvar i = 0; i < WIDTH; i++) begin : g_cell
      t_ff_cell u_cell (
         .clk (clk),
         .clr (clr),
         .t   (w_t[i]),
         .q   (q[i])
      );
   end

   // One-cycle status pulses, aligned with the new count.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_wrap     <= 1'b0;
         r_load_err <= 1'b0;
      end else begin
         r_wrap     <= w_wrap;
         r_load_err <= w_load_err;
      end
   end

   assign wrap     = r_wrap;
   assign load_err = r_load_err;

endmodule

// File: tb/tb_t_ff_updown_counter.sv
// Scoreboard bench: three counter configurations (8/3, 10/4, 2/1) share
// one stimulus stream; a modular-arithmetic model predicts each cycle.
module tb_t_ff_updown_counter;

   logic       clk = 1'b0;
   logic       clr, en, up, load;
   logic [3:0] d;

   logic [2:0] q0;  logic tc0, wr0, le0;
   logic [3:0] q1;  logic tc1, wr1, le1;
   logic [0:0] q2;  logic tc2, wr2, le2;

   always #5 clk = ~clk;

   t_ff_updown_counter #(.WIDTH(3), .MODULUS(8)) dut0 (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d[2:0]),
      .q(q0), .tc(tc0), .wrap(wr0), .load_err(le0));
   t_ff_updown_counter #(.WIDTH(4), .MODULUS(10)) dut1 (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d),
      .q(q1), .tc(tc1), .wrap(wr1), .load_err(le1));
   t_ff_updown_counter #(.WIDTH(1), .MODULUS(2)) dut2 (
      .clk(clk), .clr(clr), .en(en), .up(up), .load(load), .d(d[0:0]),
      .q(q2), .tc(tc2), .wrap(wr2), .load_err(le2));

   typedef struct packed {
      logic [2:0][3:0] q;
      logic [2:0]      w;
      logic [2:0]      l;
      logic [2:0]      tc;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_err = 0;
   bit   done  = 0;

   int mods [3] = '{8, 10, 2};
   int masks[3] = '{7, 15, 1};
   int mq[3], mw[3], ml[3];

   // One cycle: apply inputs, record what the DUTs should show now, step model.
   task automatic cyc(input logic c, input logic e, input logic u,
                      input logic l, input logic [3:0] dv);
      exp_t x;
      int   m, dd, nq, nw, nl;
      @(negedge clk);
      clr = c; en = e; up = u; load = l; d = dv;
      for (int k = 0; k < 3; k++) begin
         m        = mods[k];
         x.q[k]   = 4'(mq[k]);
         x.w[k]   = mw[k][0];
         x.l[k]   = ml[k][0];
         x.tc[k]  = e && !l && (u ? (mq[k] == m-1) : (mq[k] == 0));
         nq = mq[k]; nw = 0; nl = 0;
         if (c) begin
            nq = 0;
         end else if (l) begin
            dd = int'(dv) & masks[k];
            if (dd < m) nq = dd;
            else        nl = 1;
         end else if (e) begin
            if (u) begin nw = (mq[k] == m-1); nq = (mq[k] + 1) % m;     end
            else   begin nw = (mq[k] == 0);   nq = (mq[k] + m - 1) % m; end
         end
         mq[k] = nq; mw[k] = nw; ml[k] = nl;
      end
      exp_q.push_back(x);
   endtask

   task automatic chk(input string name, input int act, input int req);
      n_vec++;
      if (act != req) begin
         n_err++;
         $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, req);
      end
   endtask

   // Monitor: compare the DUT's present state with the queued expectation.
   initial begin
      exp_t x;
      forever begin
         @(negedge clk);
         #4;
         if (exp_q.size() != 0) begin
            x = exp_q.pop_front();
            chk("q_m8",    int'(q0),  int'(x.q[0]));
            chk("q_m10",   int'(q1),  int'(x.q[1]));
            chk("q_m2",    int'(q2),  int'(x.q[2]));
            chk("wrap_m8", int'(wr0), int'(x.w[0]));
            chk("wrap_m10",int'(wr1), int'(x.w[1]));
            chk("wrap_m2", int'(wr2), int'(x.w[2]));
            chk("lerr_m8", int'(le0), int'(x.l[0]));
            chk("lerr_m10",int'(le1), int'(x.l[1]));
            chk("lerr_m2", int'(le2), int'(x.l[2]));
            chk("tc_m8",   int'(tc0), int'(x.tc[0]));
            chk("tc_m10",  int'(tc1), int'(x.tc[1]));
            chk("tc_m2",   int'(tc2), int'(x.tc[2]));
         end
      end
   end

   // Stimulus: directed sequences from the plan, then random traffic.
   initial begin
      clr = 1'b1; en = 1'b0; up = 1'b1; load = 1'b0; d = '0;
      repeat (2) @(posedge clk);
      for (int k = 0; k < 3; k++) begin mq[k] = 0; mw[k] = 0; ml[k] = 0; end
      cyc(1, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      repeat (10) cyc(0, 1, 1, 0, 0);          // up count with wraps
      cyc(1, 0, 1, 0, 0);
      repeat (11) cyc(0, 1, 0, 0, 0);          // down count from reset
      cyc(0, 1, 1, 1, 4'd5);                   // load wins over en
      cyc(0, 1, 1, 1, 4'd12);                  // out of range for MODULUS 10
      cyc(0, 0, 1, 0, 0);
      cyc(1, 0, 1, 0, 0);
      repeat (3) cyc(0, 1, 1, 0, 0);           // count to 3
      repeat (3) cyc(0, 0, 1, 0, 0);           // hold
      for (int i = 0; i < 4; i++) cyc(0, 1, (i % 2) == 0, 0, 0);
      cyc(0, 1, 1, 1, 4'd6);
      cyc(1, 1, 1, 1, 4'd2);                   // clr beats load
      repeat (3) cyc(0, 1, 1, 0, 0);
      cyc(1, 1, 0, 1, 4'd15);                  // clr held: no pulses
      cyc(1, 1, 0, 1, 4'd15);
      for (int i = 0; i < 300; i++)
         cyc($urandom_range(0, 19) == 0, $urandom_range(0, 3) != 0,
             1'($urandom), $urandom_range(0, 7) == 0, 4'($urandom_range(0, 15)));
      cyc(0, 0, 1, 0, 0);
      repeat (3) @(negedge clk);
      if (exp_q.size() != 0) chk("drain", exp_q.size(), 0);
      done = 1;
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   // Watchdog so the run always ends.
   initial begin
      #200000;
      if (!done) begin
         $display("FAIL timeout: bench did not complete, expected completion");
         $fatal(1);
      end
   end

endmodule
